// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared types and defaults for the adder arbiter
// Contents: sequencer state enum, default NUM_REQ/WIDTH, sign bit position.
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 16;
  // Sign-magnitude: top bit is the sign, the rest is magnitude.
  localparam int SIGN_BIT    = DEF_WIDTH - 1;

endpackage

// File: rtl/adder_arbiter_if.sv
// rtl/adder_arbiter_if.sv - start/finish bus to the shared sign-magnitude adder
// Signals: add_start, add_in1, add_in2, add_sub (arbiter -> adder),
//          add_out, add_finish (adder -> arbiter).
// Modports: master = arbiter side, slave = adder side.
interface adder_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             add_start;
  logic [WIDTH-1:0] add_in1;
  logic [WIDTH-1:0] add_in2;
  logic             add_sub;
  logic [WIDTH-1:0] add_out;
  logic             add_finish;

  modport master (
    output add_start, add_in1, add_in2, add_sub,
    input  add_out, add_finish
  );

  modport slave (
    input  add_start, add_in1, add_in2, add_sub,
    output add_out, add_finish
  );
endinterface

// File: rtl/adder_arbiter_rr_pick.sv
// rtl/adder_arbiter_rr_pick.sv - combinational round-robin picker
// Ports: req (request vector), ptr (last winner index),
//        winner (one-hot), index (binary), any (some request present).
// Scan starts at ptr+1 and wraps, so the last winner has lowest priority.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         winner,
  output logic [$clog2(NUM_REQ)-1:0] index,
  output logic                       any
);
  localparam int IW = $clog2(NUM_REQ);

  always_comb begin
    winner = '0;
    index  = '0;
    any    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int          j;
      logic [IW-1:0] jj;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any        = 1'b1;
        winner[jj] = 1'b1;
        index      = jj;
      end
    end
  end
endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sequencer sharing one add/sub unit among requesters
// Ports: clk, RST (async, active-high); req/req_a/req_b/req_sub from lanes;
//        gnt/done one-hot pulses, result, busy back to lanes;
//        add (adder_arbiter_if.master) to the shared adder;
//        err timeout pulse only when ADDER_ARBITER_TIMEOUT_EN is defined.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
`ifdef ADDER_ARBITER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 15
`endif
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         result,
  output logic                     busy,
`ifdef ADDER_ARBITER_TIMEOUT_EN
  output logic                     err,
`endif
  adder_arbiter_if.master          add
);
  localparam int IW = $clog2(NUM_REQ);

  state_t              state, state_nxt;
  logic [IW-1:0]       ptr;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                grant;
  logic                timeout;
  logic [WIDTH-1:0]    a_q, b_q;
  logic                sub_q;
  logic [WIDTH-1:0]    lane_a [NUM_REQ];
  logic [WIDTH-1:0]    lane_b [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_a[i] = req_a[i*WIDTH +: WIDTH];
    assign lane_b[i] = req_b[i*WIDTH +: WIDTH];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_oh),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // A stale add_finish means the adder has not returned to idle yet.
  // Gating with RST keeps gnt low while reset is held.
  assign grant = (state == IDLE) && pick_any && !add.add_finish && !RST;

`ifdef ADDER_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;

  // tcnt equals the number of cycles already spent in ISSUE.
  assign timeout = (state == ISSUE) && !add.add_finish && (tcnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      err <= timeout;
      if (grant)
        tcnt <= '0;
      else if (state == ISSUE)
        tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge RST) begin
    if (RST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   if (add.add_finish || timeout) state_nxt = DRAIN;
      DRAIN:   if (!add.add_finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt           = grant ? pick_oh : '0;
    busy          = (state != IDLE);
    add.add_start = (state == ISSUE);
  end

  // ptr doubles as the current winner index for the whole transaction.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ptr    <= IW'(NUM_REQ - 1);
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      result <= '0;
      done   <= '0;
    end else begin
      done <= '0;
      if (grant) begin
        ptr   <= pick_idx;
        a_q   <= lane_a[pick_idx];
        b_q   <= lane_b[pick_idx];
        sub_q <= req_sub[pick_idx];
      end
      if (state == ISSUE && add.add_finish) begin
        result <= add.add_out;
        done   <= NUM_REQ'(1) << ptr;
      end else if (timeout) begin
        result <= '0;
        done   <= NUM_REQ'(1) << ptr;
      end
    end
  end

  assign add.add_in1 = a_q;
  assign add.add_in2 = b_q;
  assign add.add_sub = sub_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - self-checking bench for adder_arbiter
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_sub = '0;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   result;
  logic           busy;
`ifdef ADDER_ARBITER_TIMEOUT_EN
  logic           err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int mptr  = N - 1;

  adder_arbiter_if #(.WIDTH(W)) bus ();

`ifdef ADDER_ARBITER_TIMEOUT_EN
  adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .RST(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .gnt(gnt), .done(done), .result(result), .busy(busy), .err(err), .add(bus));
`else
  adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .RST(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .gnt(gnt), .done(done), .result(result), .busy(busy), .add(bus));
`endif

  always #5 clk = ~clk;

  function automatic logic [W-1:0] sm_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
    int va, vb, r;
    va = a[SIGN_BIT] ? -int'(a[W-2:0]) : int'(a[W-2:0]);
    vb = b[SIGN_BIT] ? -int'(b[W-2:0]) : int'(b[W-2:0]);
    if (sub) vb = -vb;
    r = va + vb;
    if (r < 0) return {1'b1, 15'(-r)};
    return {1'b0, 15'(r)};
  endfunction

  // Shared adder model: finish rises 4 cycles after start, clears once start drops.
  logic         fin_r;
  logic [W-1:0] out_r;
  int           acnt;
  bit           hold_fin = 0;
  bit           stale    = 0;
  bit           ovr_en   = 0;
  logic [W-1:0] ovr_val  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fin_r <= 1'b0;
      out_r <= '0;
      acnt  <= 0;
    end else if (bus.add_start && !fin_r) begin
      if (acnt == 3) begin
        if (!hold_fin) begin
          fin_r <= 1'b1;
          out_r <= ovr_en ? ovr_val : sm_calc(bus.add_in1, bus.add_in2, bus.add_sub);
        end
      end else begin
        acnt <= acnt + 1;
      end
    end else if (!bus.add_start) begin
      acnt  <= 0;
      fin_r <= 1'b0;
    end
  end

  assign bus.add_finish = fin_r | stale;
  assign bus.add_out    = out_r;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sub[i]      = s;
  endtask

  function automatic int model_pick(input logic [N-1:0] rq);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (mptr + k) % N;
      if (rq[i]) return i;
    end
    return -1;
  endfunction

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk); #2;
    rst  = 1'b0;
    mptr = N - 1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin @(posedge clk); #3; n++; end
    check({tag, ".idle"}, busy, 0);
  endtask

  // Single-shot transaction: req dropped after the grant edge, operands scrambled.
  task automatic run_txn(input string tag, input logic [N-1:0] rq, input int lane,
                         input logic [W-1:0] exp_res, input logic [W-1:0] post_a);
    int n;
    req = rq;
    #1;
    n = 0;
    while (gnt == '0 && n < 40) begin @(posedge clk); #3; n++; end
    check({tag, ".gnt"}, gnt, 32'(1) << lane);
    @(posedge clk); #2;
    req = '0;
    for (int i = 0; i < N; i++)
      set_lane(i, (i == lane) ? post_a : W'($urandom), W'($urandom), 1'($urandom));
    #1;
    check({tag, ".start"}, bus.add_start, 1);
    n = 0;
    while (done == '0 && n < 40) begin @(posedge clk); #3; n++; end
    check({tag, ".lat"}, n, 5);
    check({tag, ".done"}, done, 32'(1) << lane);
    check({tag, ".result"}, result, exp_res);
    @(posedge clk); #3;
    check({tag, ".done_clr"}, done, 0);
    check({tag, ".held"}, result, exp_res);
    wait_idle(tag);
    mptr = lane;
  endtask

  initial begin
    int n;
    int lane;
    logic [N-1:0] rq;
    logic [W-1:0] ea, eb;
    logic         es;

    // Reset values
    #3;
    check("rst.gnt", gnt, 0);
    check("rst.done", done, 0);
    check("rst.result", result, 0);
    check("rst.busy", busy, 0);
    check("rst.start", bus.add_start, 0);
    check("rst.in1", bus.add_in1, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Basic add / sub / negative operand
    set_lane(0, 16'h0005, 16'h0003, 1'b0);
    run_txn("add", 4'b0001, 0, 16'h0008, 16'h1234);
    set_lane(1, 16'h0003, 16'h0005, 1'b1);
    run_txn("sub", 4'b0010, 1, 16'h8002, 16'h4321);
    set_lane(1, 16'h8004, 16'h0001, 1'b0);
    run_txn("neg", 4'b0010, 1, 16'h8003, 16'h0F0F);

    // Operands change right after the grant; result uses latched values
    set_lane(3, 16'h0001, 16'h0020, 1'b0);
    run_txn("latch", 4'b1000, 3, 16'h0021, 16'h7FFF);

    // Reset in ISSUE: everything drops at once, gnt stays low under reset
    set_lane(0, 16'h0002, 16'h0002, 1'b0);
    req = 4'b0001;
    #1;
    n = 0;
    while (gnt == '0 && n < 40) begin @(posedge clk); #3; n++; end
    check("rst_mid.gnt", gnt, 1);
    @(posedge clk); #2;
    req = 4'b0100;
    #1;
    check("rst_mid.start", bus.add_start, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid.start0", bus.add_start, 0);
    check("rst_mid.gnt0", gnt, 0);
    check("rst_mid.done0", done, 0);
    check("rst_mid.busy0", busy, 0);
    @(posedge clk); #2;
    rst  = 1'b0;
    mptr = N - 1;
    set_lane(2, 16'h0100, 16'h0011, 1'b1);
    run_txn("rst_after", 4'b0100, 2, 16'h00EF, 16'h0000);

    // All four requesting continuously: strict rotation from lane 0 after reset
    reset_pulse();
    for (int i = 0; i < N; i++) set_lane(i, W'(i + 1), 16'h0010, 1'b0);
    req = 4'b1111;
    #1;
    for (int g = 0; g < 2 * N; g++) begin
      n = 0;
      while (gnt == '0 && n < 40) begin @(posedge clk); #3; n++; end
      check($sformatf("rr%0d.gnt", g), gnt, 32'(1) << (g % N));
      @(posedge clk); #3;
      n = 0;
      while (done == '0 && n < 40) begin @(posedge clk); #3; n++; end
      check($sformatf("rr%0d.done", g), done, 32'(1) << (g % N));
      check($sformatf("rr%0d.result", g), result, 32'((g % N) + 1 + 16));
    end
    req = '0;
    wait_idle("rr");
    mptr = N - 1;

    // Randomized requests against the round-robin / sign-magnitude reference
    for (int t = 0; t < 12; t++) begin
      rq = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        set_lane(i, {1'($urandom), 15'($urandom_range(0, 16383))},
                 {1'($urandom), 15'($urandom_range(0, 16383))}, 1'($urandom));
      lane = model_pick(rq);
      ea = req_a[lane*W +: W];
      eb = req_b[lane*W +: W];
      es = req_sub[lane];
      run_txn($sformatf("rnd%0d", t), rq, lane, sm_calc(ea, eb, es), W'($urandom));
    end

    // Stale add_finish in IDLE blocks granting
    stale = 1;
    set_lane(0, 16'h0007, 16'h0001, 1'b1);
    req = 4'b0001;
    #1;
    check("stale.gnt", gnt, 0);
    @(posedge clk); #3;
    check("stale.gnt2", gnt, 0);
    check("stale.busy", busy, 0);
    stale = 0;
    run_txn("stale_rel", 4'b0001, model_pick(4'b0001), 16'h0006, 16'h0000);

    // -0 from the adder is passed through unchanged
    ovr_en  = 1;
    ovr_val = 16'h8000;
    run_txn("negzero", 4'b0010, model_pick(4'b0010), 16'h8000, 16'h0000);
    ovr_en  = 0;

`ifdef ADDER_ARBITER_TIMEOUT_EN
    // Adder never finishes: timeout pulses err and done with result 0
    hold_fin = 1;
    set_lane(2, 16'h0005, 16'h0003, 1'b0);
    req = 4'b0100;
    #1;
    n = 0;
    while (gnt == '0 && n < 40) begin @(posedge clk); #3; n++; end
    check("to.gnt", gnt, 4);
    @(posedge clk); #2;
    req = '0;
    #1;
    check("to.start", bus.add_start, 1);
    n = 0;
    while (done == '0 && n < 60) begin @(posedge clk); #3; n++; end
    check("to.lat", n, TO + 1);
    check("to.err", err, 1);
    check("to.done", done, 4);
    check("to.result", result, 0);
    check("to.start0", bus.add_start, 0);
    @(posedge clk); #3;
    check("to.err_clr", err, 0);
    hold_fin = 0;
    wait_idle("to");
    mptr = 2;
    set_lane(3, 16'h0009, 16'h0004, 1'b1);
    run_txn("to_next", 4'b1000, 3, 16'h0005, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 16-bit sign-magnitude add/sub unit among NUM_REQ requesters, such as the matrix-multiplier accumulate lanes.
- Latches the granted requester's operands and drives the unit's start/finish handshake.
- Returns the result to the winner with a one-cycle done pulse.
- Sits between the matrix datapath lanes and the single shared adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand width; bit WIDTH-1 is the sign, the rest is magnitude
- TIMEOUT_CYC, 15, watchdog limit in cycles; used only with the optional feature

Ports:
- clk  in  1  clock
- RST  in  1  asynchronous reset, active-high
- req  in  NUM_REQ  level request, one bit per requester
- req_a  in  NUM_REQ*WIDTH  operand A per requester, packed with lane i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B per requester, same packing
- req_sub  in  NUM_REQ  1 = A-B, 0 = A+B, per requester
- gnt  out  NUM_REQ  one-hot grant pulse, one cycle; operands are captured on this cycle
- done  out  NUM_REQ  one-hot completion pulse, one cycle
- result  out  WIDTH  sign-magnitude result; valid while done is non-zero, held otherwise
- busy  out  1  high whenever state != IDLE
- add_start  out  1  start to the shared adder
- add_in1  out  WIDTH  latched operand A
- add_in2  out  WIDTH  latched operand B
- add_sub  out  1  latched sub flag
- add_out  in  WIDTH  adder result
- add_finish  in  1  adder finish flag
- err  out  1  timeout pulse; present only with the optional feature

Behaviour:
- Reset values: all outputs 0; state=IDLE; rr pointer=NUM_REQ-1, so requester 0 has top priority first.
- Reset is asynchronous and takes effect mid-operation: add_start drops at once. The shared adder's nRST is driven by ~RST at the top level, so both blocks reset together.

State machine:
- IDLE: if any req is high, pick the first set bit scanning from ptr+1 upward with wrap. Pulse gnt[w]; latch a, b, sub and w; set ptr=w; go to ISSUE. If no req, stay.
- ISSUE: add_start=1, add_in*/add_sub held from the latches. When add_finish=1 is sampled: register result=add_out, pulse done[w] on the next cycle, go to DRAIN.
- DRAIN: add_start=0. Wait until add_finish=0, then go to IDLE. The next grant is therefore never issued before the adder has fully returned to idle.

Timing and request rules:
- Grant-to-start latency is 1 cycle.
- Start-to-done latency is the adder latency plus 1 cycle (4+1 with the current adder).
- Operand buses are sampled only in the gnt cycle; requesters may change them afterwards.
- A req still high in the next IDLE counts as a new request. Requesters drop req on gnt for single-shot use.
- req changes outside IDLE are ignored; there is no preemption.
- Simultaneous requests: strict round-robin. With all NUM_REQ requesting continuously, each is granted exactly once per NUM_REQ grants.
- A request arriving in the same cycle done pulses is eligible at the next IDLE.
- The arbiter never inspects the sign or magnitude; result is add_out passed through. -0 (0x8000) is passed unchanged.
- add_finish already high in IDLE (stale) blocks granting until it clears.

Optional Feature:
- Macro: ADDER_ARBITER_TIMEOUT_EN.
- When defined:
  - A counter runs in ISSUE.
  - If add_finish has not arrived after TIMEOUT_CYC cycles, the block drops add_start, pulses err for 1 cycle, pulses done[w] with result=0, and goes to DRAIN.
  - The counter clears on entering ISSUE.
- When undefined: no counter and no err port; ISSUE waits indefinitely.

Decomposition:
- Package adder_arbiter_pkg: state enum (IDLE, ISSUE, DRAIN, 2-bit), default NUM_REQ/WIDTH localparams, and a sign-magnitude helper constant SIGN_BIT=WIDTH-1.
- Sub-module rr_pick: combinational round-robin picker (req vector + pointer -> one-hot winner, index, any). Instantiated once.

Test Plan:
- req=0001, a=0x0005, b=0x0003, sub=0 -> gnt=0001 next cycle, add_start high 1 cycle later, done=0001, result=0x0008, busy drops after add_finish clears.
- req=0010, a=0x0003, b=0x0005, sub=1 -> result=0x8002. Then a=0x8004, b=0x0001, sub=0 -> result=0x8003.
- req=1111 held 8 grants -> grant order 0,1,2,3,0,1,2,3; each done matches its lane's operands. Lane operands are made distinct per lane, e.g. a=i+1, b=0x0010.
- RST asserted during ISSUE -> add_start, gnt, done and busy are 0 immediately; after release, req=0100 is granted with ptr restarted.
- Operands changed the cycle after gnt (0x0001 -> 0x7FFF) -> result still reflects the latched 0x0001 + b.
- ADDER_ARBITER_TIMEOUT_EN with add_finish forced 0 -> err and done pulse at TIMEOUT_CYC+1 cycles after start, result=0x0000, next request proceeds normally.
